// File: rtl/frame_scheduler.sv
// frame_scheduler: per-frame update window control during vblank
// plus ball/hoop/background pixel priority mux.
module frame_scheduler #(
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int UPD_TIMEOUT = 40000,
  parameter int FCNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              ball_on,
  input  logic [11:0]       ball_rgb,
  input  logic              hoop_on,
  input  logic [11:0]       hoop_rgb,
  input  logic [11:0]       bg_rgb,
  input  logic              upd_ack,
  output logic              upd_req,
  output logic              frame_tick,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              overrun,
  output logic [11:0]       rgb
);

  localparam int TW = (UPD_TIMEOUT > 2) ? $clog2(UPD_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(UPD_TIMEOUT - 1);

  if (H_DISPLAY < 1 || V_DISPLAY < 1 || UPD_TIMEOUT < 2) begin : g_bad
    $error("frame_scheduler: bad timing parameters");
  end

  typedef enum logic [1:0] {
    S_ACTIVE,
    S_UPDATE,
    S_WAIT_VIS
  } state_t;

  state_t              state_q;
  logic [TW-1:0]       timer_q;
  logic                tick_q;
  logic                ovr_q;
  logic [FCNT_W-1:0]   cnt_q;
  logic [11:0]         rgb_q;
  logic [11:0]         rgb_d;
  logic                vblank_edge;
  logic                frame_edge;

  assign vblank_edge = p_tick & (pixel_x == 10'd0) &
                       (pixel_y == 10'(V_DISPLAY));
  assign frame_edge  = p_tick & (pixel_x == 10'd0) &
                       (pixel_y == 10'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ACTIVE;
      timer_q <= '0;
      tick_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        S_ACTIVE: begin
          if (vblank_edge) begin
            state_q <= S_UPDATE;
            tick_q  <= 1'b1;
            cnt_q   <= cnt_q + 1'b1;
            timer_q <= '0;
          end
        end
        S_UPDATE: begin
          // ack beats a coincident timeout or frame wrap
          if (upd_ack) begin
            state_q <= S_WAIT_VIS;
          end else if (timer_q == T_LAST || frame_edge) begin
            state_q <= S_ACTIVE;
            ovr_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_WAIT_VIS: begin
          if (frame_edge) state_q <= S_ACTIVE;
        end
        default: state_q <= S_ACTIVE;
      endcase
    end
  end

  always_comb begin
    rgb_d = 12'h000;
    if (video_on) begin
      if (ball_on)      rgb_d = ball_rgb;
      else if (hoop_on) rgb_d = hoop_rgb;
      else              rgb_d = bg_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       rgb_q <= 12'h000;
    else if (p_tick) rgb_q <= rgb_d;
  end

  assign upd_req    = (state_q == S_UPDATE);
  assign frame_tick = tick_q;
  assign frame_cnt  = cnt_q;
  assign overrun    = ovr_q;
  assign rgb        = rgb_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: handshake, timeout,
// frame-wrap abort, pixel priority and counter wrap.
module tb_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       p_tick;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       ball_on;
  logic [11:0] ball_rgb;
  logic       hoop_on;
  logic [11:0] hoop_rgb;
  logic [11:0] bg_rgb;
  logic       upd_ack;

  logic        a_req, a_tick, a_ovr;
  logic [1:0]  a_cnt;
  logic [11:0] a_rgb;
  logic        b_req, b_tick, b_ovr;
  logic [15:0] b_cnt;
  logic [11:0] b_rgb;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  frame_scheduler #(
    .UPD_TIMEOUT(1000),
    .FCNT_W(2)
  ) dut_a (
    .clk(clk), .reset(reset), .p_tick(p_tick),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .ball_on(ball_on), .ball_rgb(ball_rgb),
    .hoop_on(hoop_on), .hoop_rgb(hoop_rgb), .bg_rgb(bg_rgb),
    .upd_ack(upd_ack), .upd_req(a_req), .frame_tick(a_tick),
    .frame_cnt(a_cnt), .overrun(a_ovr), .rgb(a_rgb)
  );

  frame_scheduler #(
    .UPD_TIMEOUT(16),
    .FCNT_W(16)
  ) dut_b (
    .clk(clk), .reset(reset), .p_tick(p_tick),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .ball_on(ball_on), .ball_rgb(ball_rgb),
    .hoop_on(hoop_on), .hoop_rgb(hoop_rgb), .bg_rgb(bg_rgb),
    .upd_ack(upd_ack), .upd_req(b_req), .frame_tick(b_tick),
    .frame_cnt(b_cnt), .overrun(b_ovr), .rgb(b_rgb)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] y, input logic [9:0] x);
    pixel_y = y;
    pixel_x = x;
    p_tick  = 1'b1;
    clk1();
    p_tick  = 1'b0;
    pixel_x = 10'd5;
    pixel_y = 10'd5;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p_tick = ~p_tick;
      clk1();
    end
    p_tick = 1'b0;
    reset  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; p_tick = 1'b0; video_on = 1'b1;
    pixel_x = 10'd5; pixel_y = 10'd5;
    ball_on = 1'b1; ball_rgb = 12'hABC;
    hoop_on = 1'b0; hoop_rgb = 12'h123; bg_rgb = 12'h456;
    upd_ack = 1'b0;

    do_reset();
    chk("rst_rgb", 32'(a_rgb), 32'h000);
    chk("rst_req", 32'(a_req), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_ovr", 32'(a_ovr), 32'd0);
    chk("rst_tick", 32'(a_tick), 32'd0);

    pix(10'd480, 10'd0);
    chk("vb_tick", 32'(a_tick), 32'd1);
    chk("vb_req", 32'(a_req), 32'd1);
    chk("vb_cnt", 32'(a_cnt), 32'd1);
    clk1();
    chk("vb_tick_low", 32'(a_tick), 32'd0);
    chk("vb_req_hold", 32'(a_req), 32'd1);

    for (int i = 0; i < 98; i++) clk1();
    chk("pre_ack_req", 32'(a_req), 32'd1);
    upd_ack = 1'b1;
    clk1();
    upd_ack = 1'b0;
    chk("ack_req", 32'(a_req), 32'd0);
    chk("ack_ovr", 32'(a_ovr), 32'd0);
    upd_ack = 1'b1;
    clk1();
    upd_ack = 1'b0;
    chk("ack2_req", 32'(a_req), 32'd0);
    pix(10'd0, 10'd0);
    chk("wait_vis_req", 32'(a_req), 32'd0);
    pix(10'd480, 10'd0);
    chk("f2_cnt", 32'(a_cnt), 32'd2);
    chk("f2_req", 32'(a_req), 32'd1);

    pix(10'd0, 10'd0);
    chk("fw_req", 32'(a_req), 32'd0);
    chk("fw_ovr", 32'(a_ovr), 32'd1);
    clk1();
    chk("fw_ovr_sticky", 32'(a_ovr), 32'd1);

    do_reset();
    pix(10'd480, 10'd0);
    upd_ack = 1'b1;
    pix(10'd0, 10'd0);
    upd_ack = 1'b0;
    chk("coin_req", 32'(a_req), 32'd0);
    chk("coin_ovr", 32'(a_ovr), 32'd0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      pix(10'd480, 10'd0);
      chk($sformatf("wrap_cnt%0d", i), 32'(a_cnt),
          32'((i + 1) % 4));
      upd_ack = 1'b1;
      clk1();
      upd_ack = 1'b0;
      pix(10'd0, 10'd0);
    end

    do_reset();
    pix(10'd480, 10'd0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!b_req) break;
      n++;
      clk1();
    end
    chk("to_len", 32'(n), 32'd16);
    chk("to_req", 32'(b_req), 32'd0);
    chk("to_ovr", 32'(b_ovr), 32'd1);
    pix(10'd0, 10'd0);
    pix(10'd480, 10'd0);
    chk("to_next_tick", 32'(b_tick), 32'd1);
    chk("to_next_cnt", 32'(b_cnt), 32'd2);
    chk("to_ovr_kept", 32'(b_ovr), 32'd1);

    do_reset();
    video_on = 1'b1;
    ball_on = 1'b1; hoop_on = 1'b1;
    ball_rgb = 12'hF80; hoop_rgb = 12'h00F; bg_rgb = 12'h8CF;
    pix(10'd100, 10'd100);
    chk("mux_ball", 32'(a_rgb), 32'hF80);
    ball_on = 1'b0;
    clk1();
    clk1();
    chk("mux_hold", 32'(a_rgb), 32'hF80);
    pix(10'd100, 10'd101);
    chk("mux_hoop", 32'(a_rgb), 32'h00F);
    hoop_on = 1'b0;
    pix(10'd100, 10'd102);
    chk("mux_bg", 32'(a_rgb), 32'h8CF);
    video_on = 1'b0;
    ball_on = 1'b1;
    pix(10'd100, 10'd103);
    chk("mux_blank", 32'(a_rgb), 32'h000);
    video_on = 1'b1;
    clk1();
    chk("mux_blank_hold", 32'(a_rgb), 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
